// File: rtl/core_pipe_ctrl_pkg.sv
// core_pipe_ctrl_pkg: shared encodings for the pipeline sequencer.
//   - stage hold levels driven on hold_out
//   - bus owner encoding for bus_owner_out
//   - sequencer FSM state encoding
//   - PC value reported on jump_addr_out out of reset
package core_pipe_ctrl_pkg;

    localparam logic [1:0] HOLD_NONE = 2'd0;
    localparam logic [1:0] HOLD_PC   = 2'd1;
    localparam logic [1:0] HOLD_IF   = 2'd2;
    localparam logic [1:0] HOLD_ID   = 2'd3;

    localparam logic BUS_OWNER_IF = 1'b0;
    localparam logic BUS_OWNER_EX = 1'b1;

    localparam logic [31:0] CPU_RST_ADDRESS = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCTRL_RUN    = 2'd0,
        PCTRL_EX_MEM = 2'd1,
        PCTRL_FLUSH  = 2'd2,
        PCTRL_ERR    = 2'd3
    } pctrl_state_e;

endpackage

// File: rtl/core_pipe_ctrl_if.sv
// core_pipe_ctrl_if: request/handshake bundle between core_ex, the fetch
// unit, the memory bus and the pipeline sequencer.
//   master : the surrounding pipeline (drives requests, receives controls)
//   slave  : the sequencer itself
interface core_pipe_ctrl_if;

    logic        ex_hold_flag_in;
    logic        ex_jump_flag_in;
    logic [31:0] ex_jump_addr_in;
    logic        ex_mem_req_in;
    logic        if_req_in;
    logic        bus_ack_in;

    logic        bus_req_out;
    logic        bus_owner_out;
    logic        ex_mem_done_out;
    logic [1:0]  hold_out;
    logic        jump_flag_out;
    logic [31:0] jump_addr_out;
    logic        flush_out;
    logic        bus_err_out;

    modport master (
        output ex_hold_flag_in, ex_jump_flag_in, ex_jump_addr_in,
               ex_mem_req_in, if_req_in, bus_ack_in,
        input  bus_req_out, bus_owner_out, ex_mem_done_out, hold_out,
               jump_flag_out, jump_addr_out, flush_out, bus_err_out
    );

    modport slave (
        input  ex_hold_flag_in, ex_jump_flag_in, ex_jump_addr_in,
               ex_mem_req_in, if_req_in, bus_ack_in,
        output bus_req_out, bus_owner_out, ex_mem_done_out, hold_out,
               jump_flag_out, jump_addr_out, flush_out, bus_err_out
    );

endinterface

// File: rtl/core_ctrl_timer.sv
// core_ctrl_timer: loadable counter with a single terminal flag.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   clr       : force count to 0 (highest priority after rst)
//   load      : load load_val
//   en        : step by one (up when COUNT_UP, else down)
//   hit_o     : count == LIMIT when counting up, count == 0 when counting down
module core_ctrl_timer #(
    parameter int WIDTH    = 4,
    parameter bit COUNT_UP = 1'b0,
    parameter int LIMIT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             hit_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (load)
            cnt_d = load_val;
        else if (en)
            cnt_d = COUNT_UP ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign hit_o = COUNT_UP ? (cnt_q == WIDTH'(LIMIT)) : (cnt_q == '0);

endmodule

// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: pipeline sequencer for the RV32I core.
// Arbitrates the memory bus between fetch and EX load/store, drives the
// stage hold level, PC redirect and IF/ID flush, and traps bus timeouts.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : core_pipe_ctrl_if.slave (EX/IF requests, bus ack, all controls)
//
//   state        | meaning
//   PCTRL_RUN    | normal flow, fetch owns the bus
//   PCTRL_EX_MEM | EX load/store owns the bus until ack
//   PCTRL_FLUSH  | wrong-path bubbles after a taken jump
//   PCTRL_ERR    | bus timed out, halted until reset
module core_pipe_ctrl
    import core_pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 16
) (
    input logic             clk,
    input logic             rst,
    core_pipe_ctrl_if.slave bus
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES) + 1;
    localparam int TO_W    = $clog2(BUS_TIMEOUT) + 1;

    pctrl_state_e state_q, state_d;
    logic         jump_flag_q, jump_flag_d;
    logic [31:0]  jump_addr_q, jump_addr_d;
    logic         flush_q, flush_d;
    logic         bus_err_q, bus_err_d;

    logic         bus_req, bus_owner, ex_mem_done;
    logic [1:0]   hold;
    logic         stall, to_hit, fl_hit, fl_load, fl_en;

    always_comb begin
        bus_req     = 1'b0;
        bus_owner   = BUS_OWNER_IF;
        hold        = HOLD_NONE;
        ex_mem_done = 1'b0;
        case (state_q)
            PCTRL_RUN: begin
                bus_req = bus.if_req_in;
                if (bus.ex_jump_flag_in) begin
                    hold = HOLD_NONE;
                end else if (bus.ex_mem_req_in) begin
                    // Give the bus a dead cycle before EX takes it over.
                    hold    = HOLD_ID;
                    bus_req = 1'b0;
                end else if (bus.ex_hold_flag_in) begin
                    hold = HOLD_ID;
                end else if (bus.if_req_in && !bus.bus_ack_in) begin
                    hold = HOLD_PC;
                end
            end
            PCTRL_EX_MEM: begin
                bus_req     = 1'b1;
                bus_owner   = BUS_OWNER_EX;
                hold        = HOLD_ID;
                // A reset landing on the ack cycle must not report completion.
                ex_mem_done = bus.bus_ack_in && !rst;
            end
            PCTRL_FLUSH: begin
                bus_req = bus.if_req_in;
            end
            PCTRL_ERR: begin
                hold = HOLD_ID;
            end
        endcase
    end

    assign stall = bus_req && !bus.bus_ack_in;

    always_comb begin
        state_d     = state_q;
        jump_flag_d = 1'b0;
        jump_addr_d = jump_addr_q;
        fl_load     = 1'b0;
        fl_en       = 1'b0;
        case (state_q)
            PCTRL_RUN: begin
                if (bus.ex_jump_flag_in) begin
                    state_d     = PCTRL_FLUSH;
                    jump_flag_d = 1'b1;
                    jump_addr_d = bus.ex_jump_addr_in;
                    fl_load     = 1'b1;
                end else if (bus.ex_mem_req_in) begin
                    state_d = PCTRL_EX_MEM;
                end
            end
            PCTRL_EX_MEM: begin
                if (bus.bus_ack_in)
                    state_d = PCTRL_RUN;
            end
            PCTRL_FLUSH: begin
                if (fl_hit)
                    state_d = PCTRL_RUN;
                else
                    fl_en = 1'b1;
            end
            PCTRL_ERR: begin
                state_d = PCTRL_ERR;
            end
        endcase
        // A timeout overrides whatever the current state wanted to do.
        if (stall && to_hit) begin
            state_d     = PCTRL_ERR;
            jump_flag_d = 1'b0;
            jump_addr_d = jump_addr_q;
            fl_load     = 1'b0;
        end
        flush_d   = (state_d == PCTRL_FLUSH);
        bus_err_d = bus_err_q || (state_d == PCTRL_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PCTRL_RUN;
            jump_flag_q <= 1'b0;
            jump_addr_q <= CPU_RST_ADDRESS;
            flush_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            flush_q     <= flush_d;
            bus_err_q   <= bus_err_d;
        end
    end

    core_ctrl_timer #(
        .WIDTH    (FLUSH_W),
        .COUNT_UP (1'b0),
        .LIMIT    (0)
    ) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (fl_load),
        .load_val (FLUSH_W'(FLUSH_CYCLES - 1)),
        .en       (fl_en),
        .hit_o    (fl_hit)
    );

    // Counts consecutive unacknowledged request cycles.
    core_ctrl_timer #(
        .WIDTH    (TO_W),
        .COUNT_UP (1'b1),
        .LIMIT    (BUS_TIMEOUT - 1)
    ) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (!stall),
        .load     (1'b0),
        .load_val ('0),
        .en       (stall),
        .hit_o    (to_hit)
    );

    assign bus.bus_req_out     = bus_req;
    assign bus.bus_owner_out   = bus_owner;
    assign bus.ex_mem_done_out = ex_mem_done;
    assign bus.hold_out        = hold;
    assign bus.jump_flag_out   = jump_flag_q;
    assign bus.jump_addr_out   = jump_addr_q;
    assign bus.flush_out       = flush_q;
    assign bus.bus_err_out     = bus_err_q;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Testbench for core_pipe_ctrl: per-cycle vectors (inputs + expected outputs
// for that cycle) are driven after the rising edge, the expectation is queued,
// and a checker pops and compares it on the falling edge.
module tb_core_pipe_ctrl;
    import core_pipe_ctrl_pkg::*;

    typedef struct {
        logic        rst, hld, jmp;
        logic [31:0] addr;
        logic        mem, ifr, ack;
        logic        e_req, e_own, e_done;
        logic [1:0]  e_hold;
        logic        e_jf;
        logic [31:0] e_ja;
        logic        e_fl, e_err;
    } vec_t;

    typedef struct {
        int          tag;
        logic        req, own, done;
        logic [1:0]  hold;
        logic        jf;
        logic [31:0] ja;
        logic        fl, err;
    } exp_t;

    logic clk;
    logic rst;
    core_pipe_ctrl_if pif();

    core_pipe_ctrl #(.FLUSH_CYCLES(2), .BUS_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    int   tag_cnt = 0;
    exp_t sb[$];
    exp_t cur;
    vec_t tbl[25];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end

    function automatic vec_t mk(input logic r, h, j, input logic [31:0] a,
                                input logic m, f, k, input logic q, o, d,
                                input logic [1:0] eh, input logic jf,
                                input logic [31:0] ja, input logic fl, er);
        vec_t v;
        v.rst = r; v.hld = h; v.jmp = j; v.addr = a;
        v.mem = m; v.ifr = f; v.ack = k;
        v.e_req = q; v.e_own = o; v.e_done = d; v.e_hold = eh;
        v.e_jf = jf; v.e_ja = ja; v.e_fl = fl; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cyc%0d: got %h want %h", nm, tag, act, exp);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = v.rst;
        pif.ex_hold_flag_in = v.hld;
        pif.ex_jump_flag_in = v.jmp;
        pif.ex_jump_addr_in = v.addr;
        pif.ex_mem_req_in   = v.mem;
        pif.if_req_in       = v.ifr;
        pif.bus_ack_in      = v.ack;
        e.tag  = tag_cnt;
        e.req  = v.e_req;  e.own = v.e_own; e.done = v.e_done;
        e.hold = v.e_hold; e.jf  = v.e_jf;  e.ja   = v.e_ja;
        e.fl   = v.e_fl;   e.err = v.e_err;
        sb.push_back(e);
        tag_cnt++;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("bus_req",   cur.tag, 32'(pif.bus_req_out),     32'(cur.req));
            chk("bus_owner", cur.tag, 32'(pif.bus_owner_out),   32'(cur.own));
            chk("mem_done",  cur.tag, 32'(pif.ex_mem_done_out), 32'(cur.done));
            chk("hold",      cur.tag, 32'(pif.hold_out),        32'(cur.hold));
            chk("jump_flag", cur.tag, 32'(pif.jump_flag_out),   32'(cur.jf));
            chk("jump_addr", cur.tag, pif.jump_addr_out,        cur.ja);
            chk("flush",     cur.tag, 32'(pif.flush_out),       32'(cur.fl));
            chk("bus_err",   cur.tag, 32'(pif.bus_err_out),     32'(cur.err));
        end
    end

    initial begin
        //            rst h j addr          m f k   req own done hold     jf ja            fl err
        // reset, then idle
        tbl[0]  = mk(1, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h0,        0,0);
        tbl[1]  = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h0,        0,0);
        // fetch stall: two wait cycles then ack
        tbl[2]  = mk(0, 0,0,32'h0,        0,1,0,  1,0,0, HOLD_PC,   0,32'h0,        0,0);
        tbl[3]  = mk(0, 0,0,32'h0,        0,1,0,  1,0,0, HOLD_PC,   0,32'h0,        0,0);
        tbl[4]  = mk(0, 0,0,32'h0,        0,1,1,  1,0,0, HOLD_NONE, 0,32'h0,        0,0);
        tbl[5]  = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h0,        0,0);
        // jump to 0x100; wrong-path jump/mem during flush ignored, fetch allowed
        tbl[6]  = mk(0, 0,1,32'h100,      0,0,0,  0,0,0, HOLD_NONE, 0,32'h0,        0,0);
        tbl[7]  = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 1,32'h100,      1,0);
        tbl[8]  = mk(0, 0,1,32'h300,      1,1,1,  1,0,0, HOLD_NONE, 0,32'h100,      1,0);
        tbl[9]  = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h100,      0,0);
        // load with ack on the third bus cycle; EX inputs ignored in EX_MEM
        tbl[10] = mk(0, 0,0,32'h0,        1,0,0,  0,0,0, HOLD_ID,   0,32'h100,      0,0);
        tbl[11] = mk(0, 1,1,32'h500,      0,0,0,  1,1,0, HOLD_ID,   0,32'h100,      0,0);
        tbl[12] = mk(0, 0,0,32'h0,        0,0,0,  1,1,0, HOLD_ID,   0,32'h100,      0,0);
        tbl[13] = mk(0, 0,0,32'h0,        0,0,1,  1,1,1, HOLD_ID,   0,32'h100,      0,0);
        tbl[14] = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h100,      0,0);
        // ex_hold beats fetch wait
        tbl[15] = mk(0, 1,0,32'h0,        0,1,0,  1,0,0, HOLD_ID,   0,32'h100,      0,0);
        tbl[16] = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h100,      0,0);
        // jump + mem same cycle: jump wins, no EX_MEM
        tbl[17] = mk(0, 0,1,32'h200,      1,0,0,  0,0,0, HOLD_NONE, 0,32'h100,      0,0);
        tbl[18] = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 1,32'h200,      1,0);
        tbl[19] = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h200,      1,0);
        tbl[20] = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h200,      0,0);
        // reset during an EX transfer: ack under reset gives no done pulse
        tbl[21] = mk(0, 0,0,32'h0,        1,0,0,  0,0,0, HOLD_ID,   0,32'h200,      0,0);
        tbl[22] = mk(0, 0,0,32'h0,        0,0,0,  1,1,0, HOLD_ID,   0,32'h200,      0,0);
        tbl[23] = mk(1, 0,0,32'h0,        0,0,1,  1,1,0, HOLD_ID,   0,32'h200,      0,0);
        tbl[24] = mk(0, 0,0,32'h0,        0,0,0,  0,0,0, HOLD_NONE, 0,32'h0,        0,0);

        rst = 1'b1;
        pif.ex_hold_flag_in = 1'b0;
        pif.ex_jump_flag_in = 1'b0;
        pif.ex_jump_addr_in = 32'h0;
        pif.ex_mem_req_in   = 1'b0;
        pif.if_req_in       = 1'b0;
        pif.bus_ack_in      = 1'b0;

        foreach (tbl[i]) drive(tbl[i]);

        // Bus timeout: EX request never acked -> 16 stalled cycles, then ERR.
        drive(mk(0, 0,0,32'h0, 1,0,0, 0,0,0, HOLD_ID, 0,32'h0, 0,0));
        for (int i = 0; i < 16; i++)
            drive(mk(0, 0,0,32'h0, 0,0,0, 1,1,0, HOLD_ID, 0,32'h0, 0,0));
        // ERR is sticky and ignores every request
        for (int i = 0; i < 3; i++)
            drive(mk(0, 1,1,32'h40, 1,1,0, 0,0,0, HOLD_ID, 0,32'h0, 0,1));
        drive(mk(1, 0,0,32'h0, 0,0,0, 0,0,0, HOLD_ID,   0,32'h0, 0,1));
        drive(mk(0, 0,0,32'h0, 0,0,0, 0,0,0, HOLD_NONE, 0,32'h0, 0,0));
        // after reset a fetch works normally again
        drive(mk(0, 0,0,32'h0, 0,1,1, 1,0,0, HOLD_NONE, 0,32'h0, 0,0));

        @(posedge clk);
        @(posedge clk);
        chk("sb_drained", tag_cnt, 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
